// File: rtl/systolic_pe_pkg.sv
// Shared types and constants for the second-generation systolic PE.
package systolic_pe_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WS_RUN   = 2'd1,
    OS_ACC   = 2'd2,
    OS_DRAIN = 2'd3
  } pe_state_t;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/systolic_array_pe_v2_mac.sv
// Combinational MAC: signed multiply, sign-extend to BW_ACCU+1, add, then
// clamp or wrap. Shared by the WS and OS datapaths of the PE.
module pe_mac_sat #(
  parameter int BW_ACT   = 8,
  parameter int BW_WET   = 8,
  parameter int BW_ACCU  = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic [BW_ACT-1:0]  act,
  input  logic [BW_WET-1:0]  wet,
  input  logic [BW_ACCU-1:0] addend,
  output logic [BW_ACCU-1:0] sum,
  output logic               ovf
);

  localparam int PW = BW_ACT + BW_WET;
  localparam logic [BW_ACCU-1:0] ACC_MAX = {1'b0, {(BW_ACCU-1){1'b1}}};
  localparam logic [BW_ACCU-1:0] ACC_MIN = {1'b1, {(BW_ACCU-1){1'b0}}};

  logic signed [PW-1:0]    prod;
  logic signed [BW_ACCU:0] prod_x;
  logic signed [BW_ACCU:0] add_x;
  logic signed [BW_ACCU:0] s;

  assign prod   = $signed(act) * $signed(wet);
  assign prod_x = {{(BW_ACCU+1-PW){prod[PW-1]}}, prod};
  assign add_x  = {addend[BW_ACCU-1], addend};
  assign s      = prod_x + add_x;

  // Overflow: the guard bit disagrees with the result sign bit.
  assign ovf = s[BW_ACCU] ^ s[BW_ACCU-1];

  // Clamp toward the sign of the true sum, or just drop the guard bit.
  always_comb begin
    sum = s[BW_ACCU-1:0];
    if (SATURATE && ovf) sum = s[BW_ACCU] ? ACC_MIN : ACC_MAX;
  end

endmodule

// File: rtl/systolic_array_pe_v2.sv
// Systolic-array PE: double-buffered weights, WS and OS dataflows,
// registered activation / psum pipes and optional saturating accumulation.
module systolic_array_pe_v2
  import systolic_pe_pkg::*;
#(
  parameter int BW_ACT   = 8,
  parameter int BW_WET   = 8,
  parameter int BW_ACCU  = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               PE_enable,
  input  logic               PE_mode,
  input  logic               PE_clear_acc,
  input  logic               PE_drain,
  input  logic               PE_wet_load_valid_in,
  input  logic [BW_WET-1:0]  PE_wet_load_in,
  output logic               PE_wet_load_valid_out,
  output logic [BW_WET-1:0]  PE_wet_load_out,
  input  logic               PE_wet_swap,
  input  logic               PE_act_valid_in,
  input  logic [BW_ACT-1:0]  PE_act_in,
  output logic               PE_act_valid_out,
  output logic [BW_ACT-1:0]  PE_act_out,
  input  logic               PE_psum_valid_in,
  input  logic [BW_ACCU-1:0] PE_psum_in,
  output logic               PE_psum_valid_out,
  output logic [BW_ACCU-1:0] PE_psum_out,
  output logic               PE_sat_flag
);

  pe_state_t state, state_nxt;

  logic [BW_WET-1:0]  shadow_wet;
  logic [BW_WET-1:0]  active_wet;
  logic [BW_ACCU-1:0] acc;
  logic               drain_dumped;   // previous cycle was already OS_DRAIN

  logic [BW_WET-1:0]  mac_wet;
  logic [BW_ACCU-1:0] mac_add;
  logic [BW_ACCU-1:0] mac_sum;
  logic               mac_ovf;
  logic               mac_ws;
  logic               mac_os;

  // WS multiplies by the resident weight and adds the incoming psum;
  // OS multiplies by the weight streamed down the psum lane into acc.
  assign mac_ws  = (state == WS_RUN) && PE_act_valid_in;
  assign mac_os  = (state == OS_ACC) && PE_act_valid_in && PE_psum_valid_in;
  assign mac_wet = (state == WS_RUN) ? active_wet : PE_psum_in[BW_WET-1:0];
  assign mac_add = (state == WS_RUN) ? (PE_psum_valid_in ? PE_psum_in : '0) : acc;

  pe_mac_sat #(
    .BW_ACT   (BW_ACT),
    .BW_WET   (BW_WET),
    .BW_ACCU  (BW_ACCU),
    .SATURATE (SATURATE)
  ) u_mac (
    .act    (PE_act_in),
    .wet    (mac_wet),
    .addend (mac_add),
    .sum    (mac_sum),
    .ovf    (mac_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: mode only matters when leaving IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (PE_enable) state_nxt = (PE_mode == MODE_OS) ? OS_ACC : WS_RUN;
      WS_RUN:   if (!PE_enable) state_nxt = IDLE;
      OS_ACC:   if (!PE_enable) state_nxt = IDLE;
                else if (PE_drain) state_nxt = OS_DRAIN;
      OS_DRAIN: if (!PE_enable) state_nxt = IDLE;
                else if (!PE_drain) state_nxt = OS_ACC;
      default:  state_nxt = IDLE;
    endcase
  end

  // Activation pipe: data always forwarded, valid masked while idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      PE_act_out       <= '0;
      PE_act_valid_out <= 1'b0;
    end else begin
      PE_act_out       <= PE_act_in;
      PE_act_valid_out <= PE_act_valid_in && (state != IDLE);
    end
  end

  // Shadow weight shift chain and swap; swap sees the pre-shift shadow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_wet            <= '0;
      active_wet            <= '0;
      PE_wet_load_out       <= '0;
      PE_wet_load_valid_out <= 1'b0;
    end else begin
      PE_wet_load_valid_out <= PE_wet_load_valid_in;
      if (PE_wet_load_valid_in) begin
        shadow_wet      <= PE_wet_load_in;
        PE_wet_load_out <= shadow_wet;
      end
      if (PE_wet_swap) active_wet <= shadow_wet;
    end
  end

  // Psum lane, OS accumulator and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      PE_psum_out       <= '0;
      PE_psum_valid_out <= 1'b0;
      acc               <= '0;
      drain_dumped      <= 1'b0;
      PE_sat_flag       <= 1'b0;
    end else begin
      drain_dumped <= (state == OS_DRAIN);
      case (state)
        WS_RUN: begin
          if (PE_act_valid_in) begin
            PE_psum_out       <= mac_sum;
            PE_psum_valid_out <= 1'b1;
          end else if (PE_psum_valid_in) begin
            PE_psum_out       <= PE_psum_in;
            PE_psum_valid_out <= 1'b1;
          end else begin
            PE_psum_valid_out <= 1'b0;
          end
        end
        OS_ACC: begin
          PE_psum_out       <= PE_psum_in;
          PE_psum_valid_out <= PE_psum_valid_in;
          if (mac_os) acc <= mac_sum;
        end
        OS_DRAIN: begin
          if (!drain_dumped) begin
            PE_psum_out       <= acc;
            PE_psum_valid_out <= 1'b1;
            acc               <= '0;
          end else begin
            PE_psum_out       <= PE_psum_in;
            PE_psum_valid_out <= PE_psum_valid_in;
          end
        end
        default: PE_psum_valid_out <= 1'b0;
      endcase
      // Clear wins over a same-cycle MAC update and flag set.
      if (PE_clear_acc) begin
        acc         <= '0;
        PE_sat_flag <= 1'b0;
      end else if (SATURATE && mac_ovf && (mac_ws || mac_os)) begin
        PE_sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_pe_v2.sv
// Directed, table-driven bench: a 2-PE column (saturating) plus a wrapping
// twin of the top PE that sees identical stimulus.
module tb_systolic_array_pe_v2;

  logic clk = 1'b0;
  logic reset_n;
  logic en, mode, clr, drn, wlv, swp, av, pv, b_av;
  logic [7:0]  wl, a, b_a;
  logic [15:0] p;

  logic        t_wlv_o, t_av_o, t_pv_o, t_sat;
  logic [7:0]  t_wl_o, t_a_o;
  logic [15:0] t_p_o;
  logic        b_wlv_o, b_av_o, b_pv_o, b_sat;
  logic [7:0]  b_wl_o, b_a_o;
  logic [15:0] b_p_o;
  logic        w_wlv_o, w_av_o, w_pv_o, w_sat;
  logic [7:0]  w_wl_o, w_a_o;
  logic [15:0] w_p_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_array_pe_v2 #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(16), .SATURATE(1'b1)) u_top (
    .clk(clk), .reset_n(reset_n), .PE_enable(en), .PE_mode(mode), .PE_clear_acc(clr),
    .PE_drain(drn), .PE_wet_load_valid_in(wlv), .PE_wet_load_in(wl),
    .PE_wet_load_valid_out(t_wlv_o), .PE_wet_load_out(t_wl_o), .PE_wet_swap(swp),
    .PE_act_valid_in(av), .PE_act_in(a), .PE_act_valid_out(t_av_o), .PE_act_out(t_a_o),
    .PE_psum_valid_in(pv), .PE_psum_in(p), .PE_psum_valid_out(t_pv_o), .PE_psum_out(t_p_o),
    .PE_sat_flag(t_sat));

  systolic_array_pe_v2 #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(16), .SATURATE(1'b1)) u_bot (
    .clk(clk), .reset_n(reset_n), .PE_enable(en), .PE_mode(mode), .PE_clear_acc(clr),
    .PE_drain(drn), .PE_wet_load_valid_in(t_wlv_o), .PE_wet_load_in(t_wl_o),
    .PE_wet_load_valid_out(b_wlv_o), .PE_wet_load_out(b_wl_o), .PE_wet_swap(swp),
    .PE_act_valid_in(b_av), .PE_act_in(b_a), .PE_act_valid_out(b_av_o), .PE_act_out(b_a_o),
    .PE_psum_valid_in(t_pv_o), .PE_psum_in(t_p_o), .PE_psum_valid_out(b_pv_o), .PE_psum_out(b_p_o),
    .PE_sat_flag(b_sat));

  systolic_array_pe_v2 #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .PE_enable(en), .PE_mode(mode), .PE_clear_acc(clr),
    .PE_drain(drn), .PE_wet_load_valid_in(wlv), .PE_wet_load_in(wl),
    .PE_wet_load_valid_out(w_wlv_o), .PE_wet_load_out(w_wl_o), .PE_wet_swap(swp),
    .PE_act_valid_in(av), .PE_act_in(a), .PE_act_valid_out(w_av_o), .PE_act_out(w_a_o),
    .PE_psum_valid_in(pv), .PE_psum_in(p), .PE_psum_valid_out(w_pv_o), .PE_psum_out(w_p_o),
    .PE_sat_flag(w_sat));

  typedef struct {
    logic en, mode, clr, drn, wlv, swp, av, pv;
    logic [7:0]  wl, a;
    logic [15:0] p;
    logic eav, epv, esat;
    logic [7:0]  ea;
    logic [15:0] ep, ewp;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(input int e, md, c, d, lv, l, s, v, x, q, ps,
                              input int eav, ea, epv, ep, esat, ewp);
    vec_t t;
    t.en = 1'(e); t.mode = 1'(md); t.clr = 1'(c); t.drn = 1'(d);
    t.wlv = 1'(lv); t.wl = 8'(l); t.swp = 1'(s); t.av = 1'(v); t.a = 8'(x);
    t.pv = 1'(q); t.p = 16'(ps);
    t.eav = 1'(eav); t.ea = 8'(ea); t.epv = 1'(epv); t.ep = 16'(ep);
    t.esat = 1'(esat); t.ewp = 16'(ewp);
    return t;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    en = 0; mode = 0; clr = 0; drn = 0; wlv = 0; wl = 0; swp = 0;
    av = 0; a = 0; pv = 0; p = 0; b_av = 0; b_a = 0;
  endtask

  initial begin
    // en mode clr drn wlv wl swp av a pv p | eav ea epv ep esat ewp
    vecs[0]  = mk(1,0,0,0, 1,2, 0, 1,1,    0,0,      1,1,   1,-5,     0,-5);
    vecs[1]  = mk(1,0,0,0, 0,0, 1, 0,0,    1,7,      0,0,   1,7,      0,7);
    vecs[2]  = mk(1,0,0,0, 1,7, 0, 1,3,    1,100,    1,3,   1,106,    0,106);
    vecs[3]  = mk(1,0,0,0, 0,0, 1, 1,3,    0,0,      1,3,   1,6,      0,6);
    vecs[4]  = mk(1,0,0,0, 0,0, 0, 1,3,    0,0,      1,3,   1,21,     0,21);
    vecs[5]  = mk(1,1,0,0, 0,0, 0, 0,0,    0,0,      0,0,   0,21,     0,21);
    vecs[6]  = mk(1,1,0,0, 0,0, 0, 1,-2,   1,50,     1,-2,  1,36,     0,36);
    vecs[7]  = mk(1,0,0,0, 1,1, 0, 0,0,    0,0,      0,0,   0,36,     0,36);
    vecs[8]  = mk(1,0,0,0, 0,0, 1, 0,0,    0,0,      0,0,   0,36,     0,36);
    vecs[9]  = mk(1,0,0,0, 0,0, 0, 1,100,  1,32760,  1,100, 1,32767,  1,-32676);
    vecs[10] = mk(1,0,0,0, 0,0, 0, 1,-1,   1,5,      1,-1,  1,4,      1,4);
    vecs[11] = mk(1,0,0,0, 0,0, 0, 1,-100, 1,-32760, 1,-100,1,-32768, 1,32676);
    vecs[12] = mk(1,0,1,0, 0,0, 0, 0,0,    0,0,      0,0,   0,-32768, 0,32676);
    vecs[13] = mk(0,0,0,0, 0,0, 0, 1,2,    0,0,      1,2,   1,2,      0,2);
    vecs[14] = mk(0,0,0,0, 0,0, 0, 1,9,    0,0,      0,9,   0,2,      0,2);
    vecs[15] = mk(1,1,0,0, 0,0, 0, 1,5,    0,0,      0,5,   0,2,      0,2);
    vecs[16] = mk(1,0,0,0, 0,0, 0, 1,1,    1,4,      1,1,   1,4,      0,4);
    vecs[17] = mk(1,0,0,0, 0,0, 0, 1,2,    1,5,      1,2,   1,5,      0,5);
    vecs[18] = mk(1,0,0,0, 0,0, 0, 1,3,    1,6,      1,3,   1,6,      0,6);
    vecs[19] = mk(1,0,0,1, 0,0, 0, 0,0,    1,77,     0,0,   1,77,     0,77);
    vecs[20] = mk(1,0,0,1, 0,0, 0, 0,0,    1,99,     0,0,   1,32,     0,32);
    vecs[21] = mk(1,0,0,1, 0,0, 0, 1,10,   1,99,     1,10,  1,99,     0,99);
    vecs[22] = mk(1,0,0,1, 0,0, 0, 0,0,    0,55,     0,0,   0,55,     0,55);
    vecs[23] = mk(1,0,0,0, 0,0, 0, 0,0,    0,0,      0,0,   0,0,      0,0);
    vecs[24] = mk(1,0,0,1, 0,0, 0, 0,0,    1,33,     0,0,   1,33,     0,33);
    vecs[25] = mk(1,0,0,0, 0,0, 0, 0,0,    1,44,     0,0,   1,0,      0,0);
    vecs[26] = mk(1,0,0,0, 0,0, 0, 1,2,    1,3,      1,2,   1,3,      0,3);
    vecs[27] = mk(1,0,1,0, 0,0, 0, 1,2,    1,3,      1,2,   1,3,      0,3);
    vecs[28] = mk(1,0,0,1, 0,0, 0, 1,1,    1,9,      1,1,   1,9,      0,9);
    vecs[29] = mk(1,0,1,1, 0,0, 0, 0,0,    0,0,      0,0,   1,9,      0,9);
    vecs[30] = mk(1,0,0,0, 0,0, 0, 0,0,    0,0,      0,0,   0,0,      0,0);
    vecs[31] = mk(1,0,0,1, 0,0, 0, 0,0,    0,0,      0,0,   0,0,      0,0);
    vecs[32] = mk(1,0,0,1, 0,0, 0, 0,0,    0,12,     0,0,   1,0,      0,0);

    // Reset state.
    idle_in();
    reset_n = 0;
    step(); step();
    chk("rst psum", int'($signed(t_p_o)), 0);
    chk("rst psum_v", int'(t_pv_o), 0);
    chk("rst act_v", int'(t_av_o), 0);
    chk("rst sat", int'(t_sat), 0);
    chk("rst wl_out", int'(t_wl_o), 0);
    reset_n = 1;

    // Weight chain: 3 then -5 into the column; 3 lands in the bottom PE.
    wlv = 1; wl = 8'(3); step();
    chk("chain v_out", int'(t_wlv_o), 1);
    chk("chain out0", int'($signed(t_wl_o)), 0);
    wl = 8'(-5); step();
    chk("chain out1", int'($signed(t_wl_o)), 3);
    wlv = 0; wl = 0; step();
    chk("chain bot v", int'(b_wlv_o), 1);
    chk("chain top v", int'(t_wlv_o), 0);
    swp = 1; en = 1; step();
    swp = 0;
    av = 1; a = 8'(4); pv = 1; p = 16'(10); step();
    chk("ws top psum", int'($signed(t_p_o)), -10);
    chk("ws top psum_v", int'(t_pv_o), 1);
    av = 0; a = 0; pv = 0; p = 0; b_av = 1; b_a = 8'(2); step();
    chk("ws bot psum", int'($signed(b_p_o)), -4);
    chk("ws bot psum_v", int'(b_pv_o), 1);
    chk("ws top hold", int'($signed(t_p_o)), -10);
    b_av = 0; b_a = 0;

    // Table: one row per cycle, outputs checked just after the edge.
    for (int i = 0; i < 33; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; clr = vecs[i].clr; drn = vecs[i].drn;
      wlv = vecs[i].wlv; wl = vecs[i].wl; swp = vecs[i].swp;
      av = vecs[i].av; a = vecs[i].a; pv = vecs[i].pv; p = vecs[i].p;
      step();
      chk($sformatf("r%0d act_v", i), int'(t_av_o), int'(vecs[i].eav));
      chk($sformatf("r%0d act", i), int'($signed(t_a_o)), int'($signed(vecs[i].ea)));
      chk($sformatf("r%0d psum_v", i), int'(t_pv_o), int'(vecs[i].epv));
      chk($sformatf("r%0d psum", i), int'($signed(t_p_o)), int'($signed(vecs[i].ep)));
      chk($sformatf("r%0d sat", i), int'(t_sat), int'(vecs[i].esat));
      chk($sformatf("r%0d wrap psum", i), int'($signed(w_p_o)), int'($signed(vecs[i].ewp)));
      chk($sformatf("r%0d wrap sat", i), int'(w_sat), 0);
    end

    // Reset while draining, with every input busy.
    en = 1; drn = 1; av = 1; a = 8'(5); pv = 1; p = 16'(7); wlv = 1; wl = 8'(3); swp = 1;
    reset_n = 0;
    step();
    chk("mid rst psum", int'($signed(t_p_o)), 0);
    chk("mid rst psum_v", int'(t_pv_o), 0);
    chk("mid rst act_v", int'(t_av_o), 0);
    chk("mid rst act", int'(t_a_o), 0);
    chk("mid rst wl_out", int'(t_wl_o), 0);
    chk("mid rst wl_v", int'(t_wlv_o), 0);
    reset_n = 1;
    idle_in();
    en = 1; av = 1; a = 8'(5); step();
    chk("post rst idle act_v", int'(t_av_o), 0);
    pv = 1; p = 16'(20); step();
    chk("post rst active=0", int'($signed(t_p_o)), 20);
    chk("post rst psum_v", int'(t_pv_o), 1);
    av = 0; pv = 0; swp = 1; step();
    swp = 0; av = 1; pv = 1; step();
    chk("post rst shadow=0", int'($signed(t_p_o)), 20);
    chk("bot sat", int'(b_sat), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
